// File: rtl/tage_hist_fold_if.sv
// Fetch-side bus of the TAGE history/fold block: PC, outcome pushes, recovery
// checkpoint in; hashed index/tag, live history and ready out.
interface tage_hist_fold_if #(
    parameter int HIST_LEN = 16,
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8,
    parameter int PC_BITS  = 31
);
    logic [PC_BITS-1:0]  IN_pc;
    logic                IN_pushValid;
    logic                IN_pushTaken;
    logic                IN_recover;
    logic [HIST_LEN-1:0] IN_recoverHist;
    logic [IDX_BITS-1:0] OUT_readAddr;
    logic [TAG_BITS-1:0] OUT_readTag;
    logic [HIST_LEN-1:0] OUT_hist;
    logic                OUT_ready;

    modport master (
        output IN_pc, IN_pushValid, IN_pushTaken, IN_recover, IN_recoverHist,
        input  OUT_readAddr, OUT_readTag, OUT_hist, OUT_ready
    );

    modport slave (
        input  IN_pc, IN_pushValid, IN_pushTaken, IN_recover, IN_recoverHist,
        output OUT_readAddr, OUT_readTag, OUT_hist, OUT_ready
    );
endinterface

// File: rtl/tage_hist_fold.sv
// Speculative global history plus folded-history registers for one TAGE table;
// hashes the fetch PC into index/tag and rebuilds folds by replay after recovery.
module tage_hist_fold #(
    parameter int HIST_LEN = 16,
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8,
    parameter int PC_BITS  = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    tage_hist_fold_if.slave      bus
);
    localparam int CNT_W = $clog2(HIST_LEN + 1);
    localparam int T1_W  = TAG_BITS - 1;

    typedef enum logic {IDLE, REPLAY} state_t;

    state_t              r_state;
    logic [HIST_LEN-1:0] r_ghist;
    logic [HIST_LEN-1:0] r_replay;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_BITS-1:0] r_fI;
    logic [TAG_BITS-1:0] r_fT0;
    logic [T1_W-1:0]     r_fT1;

    logic                w_in;
    logic                w_out;
    logic [IDX_BITS-1:0] w_fI_nxt;
    logic [TAG_BITS-1:0] w_fT0_nxt;
    logic [T1_W-1:0]     w_fT1_nxt;

    // Replay feeds the checkpoint oldest-first into zeroed folds with nothing
    // leaving, so after HIST_LEN steps each bit lands at (i mod W).
    always_comb begin
        w_in  = bus.IN_pushTaken;
        w_out = r_ghist[HIST_LEN-1];
        if (r_state == REPLAY) begin
            w_in  = r_replay[HIST_LEN-1];
            w_out = 1'b0;
        end
        w_fI_nxt  = {r_fI[IDX_BITS-2:0], r_fI[IDX_BITS-1]} ^ IDX_BITS'(w_in)
                  ^ (IDX_BITS'(w_out) << (HIST_LEN % IDX_BITS));
        w_fT0_nxt = {r_fT0[TAG_BITS-2:0], r_fT0[TAG_BITS-1]} ^ TAG_BITS'(w_in)
                  ^ (TAG_BITS'(w_out) << (HIST_LEN % TAG_BITS));
        w_fT1_nxt = {r_fT1[T1_W-2:0], r_fT1[T1_W-1]} ^ T1_W'(w_in)
                  ^ (T1_W'(w_out) << (HIST_LEN % T1_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ghist  <= '0;
            r_replay <= '0;
            r_cnt    <= '0;
            r_fI     <= '0;
            r_fT0    <= '0;
            r_fT1    <= '0;
        end else if (bus.IN_recover) begin
            r_state  <= REPLAY;
            r_ghist  <= bus.IN_recoverHist;
            r_replay <= bus.IN_recoverHist;
            r_cnt    <= CNT_W'(HIST_LEN);
            r_fI     <= '0;
            r_fT0    <= '0;
            r_fT1    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.IN_pushValid) begin
                        r_ghist <= {r_ghist[HIST_LEN-2:0], bus.IN_pushTaken};
                        r_fI    <= w_fI_nxt;
                        r_fT0   <= w_fT0_nxt;
                        r_fT1   <= w_fT1_nxt;
                    end
                end
                REPLAY: begin
                    r_replay <= {r_replay[HIST_LEN-2:0], 1'b0};
                    r_cnt    <= r_cnt - 1'b1;
                    r_fI     <= w_fI_nxt;
                    r_fT0    <= w_fT0_nxt;
                    r_fT1    <= w_fT1_nxt;
                    if (r_cnt == CNT_W'(1))
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.OUT_readAddr = bus.IN_pc[IDX_BITS-1:0] ^ r_fI;
    assign bus.OUT_readTag  = bus.IN_pc[TAG_BITS-1:0] ^ r_fT0 ^ {r_fT1, 1'b0};
    assign bus.OUT_hist     = r_ghist;
    assign bus.OUT_ready    = (r_state == IDLE);
endmodule

// File: tb/tb_tage_hist_fold.sv
// Directed bench for tage_hist_fold: pushes, wrap cancellation, recovery replay,
// recover/push collisions, nested recover and mid-replay reset.
module tb_tage_hist_fold;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    tage_hist_fold_if #(.HIST_LEN(16), .IDX_BITS(6), .TAG_BITS(8), .PC_BITS(31)) ifc ();

    tage_hist_fold #(.HIST_LEN(16), .IDX_BITS(6), .TAG_BITS(8), .PC_BITS(31)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifc.IN_pc = '0;
        ifc.IN_pushValid = 1'b0;
        ifc.IN_pushTaken = 1'b0;
        ifc.IN_recover = 1'b0;
        ifc.IN_recoverHist = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push(input logic taken);
        ifc.IN_pushValid = 1'b1;
        ifc.IN_pushTaken = taken;
        step();
        ifc.IN_pushValid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        chk("reset_ready", 32'(ifc.OUT_ready), 32'h1);
        chk("reset_hist",  32'(ifc.OUT_hist), 32'h0);
        chk("reset_addr",  32'(ifc.OUT_readAddr), 32'h0);
        chk("reset_tag",   32'(ifc.OUT_readTag), 32'h0);
    endtask

    task automatic test_push_one();
        do_reset();
        push(1'b1);
        chk("push1_hist", 32'(ifc.OUT_hist), 32'h0001);
        chk("push1_addr", 32'(ifc.OUT_readAddr), 32'h01);
        chk("push1_tag",  32'(ifc.OUT_readTag), 32'h03);
    endtask

    // 1,0,1,1 -> ghist 0xB; all folds 0xB; tag = 0xB ^ (0xB<<1) = 0x1D.
    task automatic test_pattern();
        do_reset();
        push(1'b1); push(1'b0); push(1'b1); push(1'b1);
        chk("pat_hist", 32'(ifc.OUT_hist), 32'h000B);
        chk("pat_addr", 32'(ifc.OUT_readAddr), 32'h0B);
        chk("pat_tag",  32'(ifc.OUT_readTag), 32'h1D);
        ifc.IN_pc = 31'h55;
        #1;
        chk("pat_pc_addr", 32'(ifc.OUT_readAddr), 32'h1E);
        chk("pat_pc_tag",  32'(ifc.OUT_readTag), 32'h48);
        ifc.IN_pc = '0;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) push(1'b1);
        chk("wrap16_hist", 32'(ifc.OUT_hist), 32'hFFFF);
        chk("wrap16_addr", 32'(ifc.OUT_readAddr), 32'h0F);
        chk("wrap16_tag",  32'(ifc.OUT_readTag), 32'h06);
        push(1'b1);
        chk("wrap17_hist", 32'(ifc.OUT_hist), 32'hFFFF);
        chk("wrap17_addr", 32'(ifc.OUT_readAddr), 32'h0F);
        chk("wrap17_tag",  32'(ifc.OUT_readTag), 32'h06);
    endtask

    task automatic test_recover();
        do_reset();
        ifc.IN_recover = 1'b1;
        ifc.IN_recoverHist = 16'hFFFF;
        step();
        ifc.IN_recover = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("rec_busy%0d", k), 32'(ifc.OUT_ready), 32'h0);
            step();
        end
        chk("rec_ready", 32'(ifc.OUT_ready), 32'h1);
        chk("rec_hist",  32'(ifc.OUT_hist), 32'hFFFF);
        chk("rec_addr",  32'(ifc.OUT_readAddr), 32'h0F);
        chk("rec_tag",   32'(ifc.OUT_readTag), 32'h06);
    endtask

    task automatic test_recover_push();
        do_reset();
        push(1'b1); push(1'b1); push(1'b1);
        ifc.IN_recover = 1'b1;
        ifc.IN_recoverHist = 16'h0000;
        ifc.IN_pushValid = 1'b1;
        ifc.IN_pushTaken = 1'b1;
        step();
        ifc.IN_recover = 1'b0;
        for (int k = 0; k < 16; k++) step();
        ifc.IN_pushValid = 1'b0;
        chk("rp_ready", 32'(ifc.OUT_ready), 32'h1);
        chk("rp_hist",  32'(ifc.OUT_hist), 32'h0000);
        chk("rp_addr",  32'(ifc.OUT_readAddr), 32'h00);
        chk("rp_tag",   32'(ifc.OUT_readTag), 32'h00);
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        ifc.IN_recover = 1'b1;
        ifc.IN_recoverHist = 16'hFFFF;
        step();
        ifc.IN_recover = 1'b0;
        for (int k = 0; k < 4; k++) step();
        ifc.IN_recover = 1'b1;
        ifc.IN_recoverHist = 16'h0001;
        step();
        ifc.IN_recover = 1'b0;
        n = 1;
        while (ifc.OUT_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("b2b_latency", 32'(n), 32'd17);
        chk("b2b_hist", 32'(ifc.OUT_hist), 32'h0001);
        chk("b2b_addr", 32'(ifc.OUT_readAddr), 32'h01);
        chk("b2b_tag",  32'(ifc.OUT_readTag), 32'h03);
    endtask

    task automatic test_reset_mid_replay();
        do_reset();
        ifc.IN_recover = 1'b1;
        ifc.IN_recoverHist = 16'hFFFF;
        step();
        ifc.IN_recover = 1'b0;
        for (int k = 0; k < 3; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_ready", 32'(ifc.OUT_ready), 32'h1);
        chk("mrst_hist",  32'(ifc.OUT_hist), 32'h0);
        chk("mrst_addr",  32'(ifc.OUT_readAddr), 32'h0);
        ifc.IN_pc = 31'h2A;
        #1;
        chk("mrst_pc_addr", 32'(ifc.OUT_readAddr), 32'h2A);
        chk("mrst_pc_tag",  32'(ifc.OUT_readTag), 32'h2A);
        step();
        chk("mrst_stays_idle", 32'(ifc.OUT_ready), 32'h1);
        ifc.IN_pc = '0;
    endtask

    initial begin
        test_reset();
        test_push_one();
        test_pattern();
        test_wrap();
        test_recover();
        test_recover_push();
        test_back_to_back();
        test_reset_mid_replay();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
